game_tick_scheduler: RTL and testbench

Divides the 20 kHz base game tick into N_CH independent periodic update events, e.g. alien march, missile step, player step and sprite animation. Arbitrates simultaneous expiries so that only one event is presented at a time to the shared game-state update engine. The engine consumes each event through a valid/ack handshake. The block sits between the base tick generator and the game logic FSM.

---
 rtl/game_tick_scheduler.sv | 151 +++++++++++++++
 tb/tb_game_tick_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : game_tick_scheduler
// Description : Divides the base game tick into N_CH periodic update events
//               and presents them one at a time to the game-state update
//               engine over a valid/ack handshake.
//               Simultaneous expiries are serialised by an arbiter. By
//               default it is round-robin. When TICK_SCHED_FIXED_PRIO_EN is
//               defined, the lowest pending index wins and there is no
//               rr_ptr.
// Ports       : clk        - system clock
//               reset      - synchronous active-high reset
//               tick       - one-cycle base tick
//               pause      - ignore ticks, freeze counters
//               cfg_load   - load div_cfg into the dividers
//               div_cfg    - packed divisors, ch0 in the LSBs (0 = off)
//               ovr_clr    - clear all overrun flags
//               evt_ack    - consumer accepts presented event
//               evt_valid  - event presented
//               evt_id     - index of presented channel
//               evt_onehot - one-hot of evt_id, zero when idle
//               overrun    - sticky per-channel overrun flags
// Revision    : 1.0 - initial release
// ============================================================================
module game_tick_scheduler #(
  parameter int                    N_CH     = 4,
  parameter int                    CNT_W    = 16,
  parameter logic [N_CH*CNT_W-1:0] DIV_INIT = {16'd0, 16'd100, 16'd400, 16'd1000},
  parameter int                    IDW      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  pause,
  input  logic                  cfg_load,
  input  logic [N_CH*CNT_W-1:0] div_cfg,
  input  logic                  ovr_clr,
  input  logic                  evt_ack,
  output logic                  evt_valid,
  output logic [IDW-1:0]        evt_id,
  output logic [N_CH-1:0]       evt_onehot,
  output logic [N_CH-1:0]       overrun
);

  // Counter start value for a given divisor: first expiry lands on tick div.
  function automatic logic [CNT_W-1:0] first_cnt(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] div_q [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  expire;
  logic [N_CH-1:0]  gnt_mask;
  logic [N_CH-1:0]  new_ovr;
  logic [N_CH-1:0]  pend_nxt;
  logic [IDW-1:0]   winner;
  logic             found;
  logic             grant;
  logic             run_tick;

`ifndef TICK_SCHED_FIXED_PRIO_EN
  logic [IDW-1:0]   rr_ptr;
`endif

  // cfg_load wins over a coincident tick, so that tick never reaches counters.
  assign run_tick = tick & ~pause & ~cfg_load;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign expire[i] = run_tick && (div_q[i] != '0) && (cnt_q[i] == '0);
  end

  // Winner selection over the registered pend bits.
  always_comb begin
    winner = '0;
    found  = 1'b0;
`ifdef TICK_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < N_CH; k++) begin
      if (!found && pend[k]) begin
        found  = 1'b1;
        winner = IDW'(k);
      end
    end
`else
    // Search starts one past the last winner and wraps, ending on it.
    for (int k = 1; k <= N_CH; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N_CH;
      if (!found && pend[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
`endif
  end

  always_comb begin
    grant    = found && (!evt_valid || evt_ack);
    gnt_mask = grant ? (N_CH'(1) << winner) : '0;
    // An expiry on the cycle its own pend bit is granted away is not an
    // overrun; the bit simply stays set for the new expiry.
    new_ovr  = expire & pend & ~gnt_mask;
    pend_nxt = cfg_load ? '0 : ((pend & ~gnt_mask) | expire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        div_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
        cnt_q[i] <= first_cnt(DIV_INIT[i*CNT_W +: CNT_W]);
      end
      pend       <= '0;
      overrun    <= '0;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_onehot <= '0;
`ifndef TICK_SCHED_FIXED_PRIO_EN
      rr_ptr     <= IDW'(N_CH - 1);
`endif
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_load) begin
          div_q[i] <= div_cfg[i*CNT_W +: CNT_W];
          cnt_q[i] <= first_cnt(div_cfg[i*CNT_W +: CNT_W]);
        end else if (run_tick && (div_q[i] != '0)) begin
          cnt_q[i] <= (cnt_q[i] == '0) ? (div_q[i] - CNT_W'(1))
                                       : (cnt_q[i] - CNT_W'(1));
        end
      end

      pend <= pend_nxt;

      // A new overrun in the clearing cycle keeps its flag.
      overrun <= (ovr_clr ? '0 : overrun) | new_ovr;

      if (grant) begin
        evt_valid  <= 1'b1;
        evt_id     <= winner;
        evt_onehot <= N_CH'(1) << winner;
`ifndef TICK_SCHED_FIXED_PRIO_EN
        rr_ptr     <= winner;
`endif
      end else if (evt_valid && evt_ack) begin
        evt_valid  <= 1'b0;
        evt_onehot <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_game_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_tick_scheduler
// Description : Directed self-checking bench for game_tick_scheduler with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_tick_scheduler;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  reset;
  logic                  tick;
  logic                  pause;
  logic                  cfg_load;
  logic [N_CH*CNT_W-1:0] div_cfg;
  logic                  ovr_clr;
  logic                  evt_ack;
  logic                  evt_valid;
  logic [IDW-1:0]        evt_id;
  logic [N_CH-1:0]       evt_onehot;
  logic [N_CH-1:0]       overrun;

  int n_chk;
  int n_pass;
  int cyc;
  int ev_cnt [N_CH];
  int first0;
  int first1;
  int oh_bad;
  int nv;

  game_tick_scheduler #(
    .N_CH     (N_CH),
    .CNT_W    (CNT_W),
    .DIV_INIT ({16'd0, 16'd100, 16'd400, 16'd1000}),
    .IDW      (IDW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .pause      (pause),
    .cfg_load   (cfg_load),
    .div_cfg    (div_cfg),
    .ovr_clr    (ovr_clr),
    .evt_ack    (evt_ack),
    .evt_valid  (evt_valid),
    .evt_id     (evt_id),
    .evt_onehot (evt_onehot),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // One clock edge; outputs are then sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic observe();
    if (evt_valid) begin
      ev_cnt[evt_id]++;
      if (evt_onehot !== (4'b0001 << evt_id)) oh_bad++;
      if (evt_id == 2'd0 && first0 == 0) first0 = cyc;
      if (evt_id == 2'd1 && first1 == 0) first1 = cyc;
    end
  endtask

  initial begin
    logic [IDW-1:0] rr_exp [5];
    n_chk = 0; n_pass = 0; cyc = 0; first0 = 0; first1 = 0; oh_bad = 0; nv = 0;
    for (int i = 0; i < N_CH; i++) ev_cnt[i] = 0;
    reset = 1'b1; tick = 1'b0; pause = 1'b0; cfg_load = 1'b0;
    div_cfg = '0; ovr_clr = 1'b0; evt_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_valid",  32'(evt_valid),  32'd0);
    check("rst_id",     32'(evt_id),     32'd0);
    check("rst_onehot", 32'(evt_onehot), 32'd0);
    check("rst_ovr",    32'(overrun),    32'd0);

    // Default divisors, ack tied high, 1000 ticks.
    evt_ack = 1'b1; cyc = 0;
    for (int k = 1; k <= 1000; k++) begin
      tick = 1'b1; step(); observe();
    end
    tick = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(); observe();
    end
    check("t1_ch0_cnt",   32'(ev_cnt[0]), 32'd1);
    check("t1_ch0_first", 32'(first0),    32'd1001);
    check("t1_ch1_cnt",   32'(ev_cnt[1]), 32'd2);
    check("t1_ch1_first", 32'(first1),    32'd401);
    check("t1_ch2_cnt",   32'(ev_cnt[2]), 32'd10);
    check("t1_ch3_cnt",   32'(ev_cnt[3]), 32'd0);
    check("t1_onehot",    32'(oh_bad),    32'd0);
    check("t1_ovr",       32'(overrun),   32'd0);

    // All divisors 1, ack held low: overruns build up.
    reset = 1'b1; step(); reset = 1'b0;
    evt_ack = 1'b0;
    cfg_load = 1'b1; div_cfg = {4{16'd1}}; step(); cfg_load = 1'b0;
    tick = 1'b1; step();
    check("t2_tk1_valid", 32'(evt_valid), 32'd0);
    check("t2_tk1_ovr",   32'(overrun),   32'd0);
    step();
    check("t2_tk2_valid", 32'(evt_valid), 32'd1);
    check("t2_tk2_id",    32'(evt_id),    32'd0);
    check("t2_tk2_ovr",   32'(overrun),   32'b1110);
    step();
    check("t2_tk3_id",    32'(evt_id),    32'd0);
    check("t2_tk3_ovr",   32'(overrun),   32'b1111);
    tick = 1'b0; ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    check("t2_clr_ovr",   32'(overrun),   32'd0);
    check("t2_clr_valid", 32'(evt_valid), 32'd1);

    // Single tick, all divisors 1, ack high: back-to-back 0,1,2,3.
    reset = 1'b1; step(); reset = 1'b0;
    evt_ack = 1'b1;
    cfg_load = 1'b1; step(); cfg_load = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    check("t3_lat_valid", 32'(evt_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t3_seq_valid",  32'(evt_valid),  32'd1);
      check("t3_seq_id",     32'(evt_id),     32'(k));
      check("t3_seq_onehot", 32'(evt_onehot), 32'(4'b0001 << k));
    end
    step();
    check("t3_end_valid",  32'(evt_valid),  32'd0);
    check("t3_end_onehot", 32'(evt_onehot), 32'd0);

    // Round-robin fairness between ch2 and ch3.
    cfg_load = 1'b1; div_cfg = {16'd1, 16'd1, 16'd0, 16'd0}; step(); cfg_load = 1'b0;
    rr_exp[0] = 2'd2; rr_exp[1] = 2'd3; rr_exp[2] = 2'd2; rr_exp[3] = 2'd3; rr_exp[4] = 2'd2;
    tick = 1'b1; step();
    check("t4_lat_valid", 32'(evt_valid), 32'd0);
    for (int j = 0; j < 5; j++) begin
      tick = (j < 3);
      step();
      check("t4_rr_id", 32'(evt_id), 32'(rr_exp[j]));
    end
    tick = 1'b0; step();
    check("t4_end_valid", 32'(evt_valid), 32'd0);

    // Pause with ch0 div 10.
    reset = 1'b1; step(); reset = 1'b0;
    evt_ack = 1'b0;
    cfg_load = 1'b1; div_cfg = {48'd0, 16'd10}; step(); cfg_load = 1'b0;
    tick = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check("t5_tk10_valid", 32'(evt_valid), 32'd0);
    step();
    check("t5_tk11_valid", 32'(evt_valid), 32'd1);
    check("t5_tk11_id",    32'(evt_id),    32'd0);
    step(); step();
    pause = 1'b1; evt_ack = 1'b1; step(); evt_ack = 1'b0;
    check("t5_drain", 32'(evt_valid), 32'd0);
    nv = 0;
    for (int k = 0; k < 49; k++) begin
      step(); if (evt_valid) nv++;
    end
    check("t5_pause_evts", 32'(nv), 32'd0);
    pause = 1'b0; nv = 0;
    for (int k = 0; k < 7; k++) begin
      step(); if (evt_valid) nv++;
    end
    check("t5_resume_early", 32'(nv), 32'd0);
    tick = 1'b0; step();
    check("t5_resume_valid", 32'(evt_valid), 32'd1);
    check("t5_resume_id",    32'(evt_id),    32'd0);

    // cfg_load with a coincident tick and an outstanding event.
    cfg_load = 1'b1; div_cfg = {4{16'd1}}; step(); cfg_load = 1'b0;
    check("t6_keep_valid", 32'(evt_valid), 32'd1);
    tick = 1'b1; step();
    cfg_load = 1'b1; step(); cfg_load = 1'b0; tick = 1'b0;
    check("t6_cfg_valid", 32'(evt_valid), 32'd1);
    check("t6_cfg_id",    32'(evt_id),    32'd0);
    check("t6_cfg_ovr",   32'(overrun),   32'd0);
    evt_ack = 1'b1; step(); evt_ack = 1'b0;
    check("t6_pend_clr",  32'(evt_valid), 32'd0);

    // Reset in the middle of a handshake.
    tick = 1'b1; step(); tick = 1'b0; step();
    check("t6_pre_rst_valid", 32'(evt_valid), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_rst_valid",  32'(evt_valid),  32'd0);
    check("t6_rst_onehot", 32'(evt_onehot), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
